data_memory: RTL and testbench

- Off-chip main memory model behind the CPU's data cache.
- Stores 512 lines of 256 bits (16 KB).
- Serves whole-line read and write requests over an enable/ack handshake with a fixed multi-cycle latency.
- The array is directly accessible by hierarchical name (`memory`) so benches can preload and inspect it.

---
 rtl/data_memory.sv | 77 +++++++
 tb/tb_data_memory.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Off-chip main memory model: DEPTH lines of LINE_BITS bits, whole-line read/write
// over an enable/ack handshake with a fixed LATENCY-cycle response.
module data_memory #(
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned LATENCY   = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OFS_W = $clog2(LINE_BITS / 8);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [IDX_W-1:0]     index;
    logic [LINE_BITS-1:0] memory [0:DEPTH-1];
    logic                 unused_addr_bits;

    // Byte-within-line and high address bits are ignored: addresses alias modulo the array size.
    assign index            = addr_i[OFS_W +: IDX_W];
    assign unused_addr_bits = ^{addr_i[31:OFS_W+IDX_W], addr_i[OFS_W-1:0]};

    always_comb begin
        ack_o  = (state == WAIT) && (count == LAST);
        data_o = '0;
        if (ack_o) begin
            data_o = memory[index];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (enable_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == LAST) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // The write lands on the edge that closes the ack cycle, so data_o still shows the old line.
    always_ff @(posedge clk_i) begin
        if (!rst_i && ack_o && write_i) begin
            memory[index] <= data_i;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed latency/aliasing/reset cases plus randomized
// requests, checked every cycle against a timestamp-based request model.
module tb_data_memory;
    localparam int DEPTH = 512;
    localparam int LB    = 256;
    localparam int LAT   = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          write;
    logic [31:0]   addr;
    logic [LB-1:0] din;
    logic [LB-1:0] dout;
    logic          ack;

    data_memory #(.DEPTH(DEPTH), .LINE_BITS(LB), .LATENCY(LAT)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (addr),
        .data_i  (din),
        .enable_i(enable),
        .write_i (write),
        .ack_o   (ack),
        .data_o  (dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [LB-1:0] model_mem [0:DEPTH-1];
    bit            busy        = 1'b0;
    bit            armed       = 1'b0;
    int            edge_no     = 0;
    int            accept_edge = 0;
    logic          exp_ack;

    function automatic int idx_of(logic [31:0] a);
        return int'(a[13:5]);
    endfunction

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        for (int k = 0; k < LB / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Request model: a request accepted at edge E completes (acks) between edges E+LAT-1 and E+LAT.
    always @(posedge clk) begin
        edge_no++;
        if (rst) begin
            busy  = 1'b0;
            armed = 1'b1;
        end else if (!busy) begin
            if (enable) begin
                busy        = 1'b1;
                accept_edge = edge_no;
            end
        end else if (edge_no - accept_edge == LAT) begin
            if (write) model_mem[idx_of(addr)] = din;
            busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            exp_ack = busy && (edge_no - accept_edge == LAT - 1);
            check("ack", LB'(ack), LB'(exp_ack));
            check("data", dout, exp_ack ? model_mem[idx_of(addr)] : '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step();
    endtask

    // Issue one request; returns the number of cycles after acceptance at which ack was seen.
    task automatic do_req(input logic [31:0] a, input logic [LB-1:0] d, input bit w, input int drop_at,
                          output int ack_n, output logic [LB-1:0] ack_data);
        addr     = a;
        din      = d;
        write    = w;
        enable   = 1'b1;
        ack_n    = -1;
        ack_data = '0;
        step();
        for (int n = 1; n <= 3 * LAT; n++) begin
            if (n == drop_at) enable = 1'b0;
            if (ack) begin
                ack_n    = n;
                ack_data = dout;
                enable   = 1'b0;
                break;
            end
            step();
        end
        if (ack_n < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no ack within %0d cycles (addr %h)", 3 * LAT, a);
            enable = 1'b0;
        end
    endtask

    initial begin
        logic [LB-1:0] rd, d1, d2, old_line;
        int            n, t1, t2, acks;

        rst    = 1'b1;
        enable = 1'b0;
        write  = 1'b0;
        addr   = '0;
        din    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd            = rand_line();
            dut.memory[i] = rd;
            model_mem[i]  = rd;
        end
        dut.memory[0] = 256'h5;
        model_mem[0]  = 256'h5;

        idle_cycles(2);
        rst = 1'b0;
        check("reset_ack", LB'(ack), '0);
        check("reset_data", dout, '0);

        // Read latency
        do_req(32'h0, '0, 1'b0, -1, n, rd);
        check("read_latency", LB'(n), LB'(10));
        check("read_data", rd, 256'h5);
        idle_cycles(1);
        check("ack_single_cycle", LB'(ack), '0);

        // Write then read same line
        old_line = model_mem[32];
        do_req(32'h400, {8{32'hDEADBEEF}}, 1'b1, -1, n, rd);
        check("write_latency", LB'(n), LB'(10));
        check("write_ack_old_data", rd, old_line);
        check("mem32_before_close", dut.memory[32], old_line);
        idle_cycles(1);
        check("mem32_after_close", dut.memory[32], {8{32'hDEADBEEF}});
        do_req(32'h41C, '0, 1'b0, -1, n, rd);
        check("readback_41c", rd, {8{32'hDEADBEEF}});
        idle_cycles(1);

        // Aliasing modulo 16 KB
        do_req(32'h4020, 256'hA, 1'b1, -1, n, rd);
        idle_cycles(1);
        check("alias_mem1", dut.memory[1], 256'hA);
        do_req(32'h20, '0, 1'b0, -1, n, rd);
        check("alias_read_20", rd, 256'hA);
        idle_cycles(1);

        // Reset in the middle of a write
        old_line = model_mem[3];
        addr     = 32'h60;
        din      = rand_line();
        write    = 1'b1;
        enable   = 1'b1;
        step();
        enable = 1'b0;
        idle_cycles(4);
        rst = 1'b1;
        step();
        rst  = 1'b0;
        acks = 0;
        for (int t = 0; t < 15; t++) begin
            if (ack) acks++;
            step();
        end
        check("reset_abort_noack", LB'(acks), '0);
        check("reset_abort_mem3", dut.memory[3], old_line);
        check("reset_abort_count", LB'(dut.count), '0);

        // Back-to-back reads with enable held
        addr   = 32'h0;
        write  = 1'b0;
        enable = 1'b1;
        t1     = -1;
        t2     = -1;
        d1     = '0;
        d2     = '0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (t1 >= 0 && t == t1 + 1) addr = 32'h20;
            if (ack) begin
                if (t1 < 0) begin
                    t1 = t;
                    d1 = dout;
                end else begin
                    t2 = t;
                    d2 = dout;
                    break;
                end
            end
        end
        enable = 1'b0;
        check("b2b_gap", LB'(t2 - t1), LB'(11));
        check("b2b_data0", d1, 256'h5);
        check("b2b_data1", d2, 256'hA);
        idle_cycles(1);

        // enable dropped during WAIT
        do_req(32'h20, '0, 1'b0, 2, n, rd);
        check("drop_latency", LB'(n), LB'(10));
        check("drop_data", rd, 256'hA);
        idle_cycles(1);

        // Randomized requests against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a       = $urandom();
            a[13:5] = 9'($urandom_range(0, 15));
            do_req(a, rand_line(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), n, rd);
            check("rand_latency", LB'(n), LB'(10));
            idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
